// File: rtl/data_clk_gen_pkg.sv
// rtl/data_clk_gen_pkg.sv - shared FSM encoding and ratio constants for the data clock generator
package data_clk_gen_pkg;

  // Three-state generator FSM
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  // Smallest usable period; lower requests are clamped to this and flagged
  localparam int MIN_RATIO = 2;

endpackage

// File: rtl/data_clk_gen_if.sv
// rtl/data_clk_gen_if.sv - request and output bundle of the data clock generator
interface data_clk_gen_if #(
  parameter int DIV_W  = 6,
  parameter int PCNT_W = 16
);
  logic              en;
  logic [DIV_W-1:0]  div_ratio;
  logic              clk_data;
  logic              data_strobe;
  logic              active;
  logic              cfg_err;
  logic [PCNT_W-1:0] period_cnt;

  modport master (
    output en, div_ratio,
    input  clk_data, data_strobe, active, cfg_err, period_cnt
  );

  modport slave (
    input  en, div_ratio,
    output clk_data, data_strobe, active, cfg_err, period_cnt
  );
endinterface

// File: rtl/data_clk_gen_strobe_counter.sv
// rtl/data_clk_gen_strobe_counter.sv - wrapping count of emitted data strobes
module strobe_counter #(
  parameter int PCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_strobe,
  output logic [PCNT_W-1:0] o_period_cnt
);

  logic [PCNT_W-1:0] r_period_cnt;

  // Count one per registered strobe, so the new value shows the cycle after the pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_period_cnt <= '0;
    end else if (i_strobe) begin
      r_period_cnt <= r_period_cnt + PCNT_W'(1);
    end
  end

  assign o_period_cnt = r_period_cnt;

endmodule

// File: rtl/data_clk_gen.sv
// rtl/data_clk_gen.sv - programmable-period data clock generator with start/stop FSM
module data_clk_gen
  import data_clk_gen_pkg::*;
#(
  parameter int DIV_W  = 6,
  parameter int PCNT_W = 16
) (
  input logic         clk,
  input logic         rst,
  data_clk_gen_if.slave bus
);

  localparam logic [DIV_W-1:0] L_MIN = DIV_W'(MIN_RATIO);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_n_lat;
  logic             r_clk_data;
  logic             r_strobe;
  logic             r_active;
  logic             r_cfg_err;

  logic             w_wrap;
  logic             w_start;
  logic             w_low_req;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic [DIV_W-1:0] w_n_nxt;
  logic             w_clk_nxt;

  assign w_wrap    = (r_cnt == (r_n_lat - DIV_W'(1)));
  assign w_low_req = (bus.div_ratio < L_MIN);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: a dropped request lets the running period finish before idling
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: w_state_nxt = bus.en ? ST_RUN : ST_IDLE;
      ST_RUN: begin
        if (!bus.en) begin
          w_state_nxt = w_wrap ? ST_IDLE : ST_STOP;
        end
      end
      ST_STOP: begin
        if (bus.en) begin
          w_state_nxt = ST_RUN;
        end else if (w_wrap) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: period start, ratio latch and next phase of the data clock
  always_comb begin
    w_start   = (w_state_nxt == ST_RUN) && ((r_state == ST_IDLE) || w_wrap);
    w_n_nxt   = r_n_lat;
    if (w_start) begin
      w_n_nxt = w_low_req ? L_MIN : bus.div_ratio;
    end
    w_cnt_nxt = r_cnt + DIV_W'(1);
    if ((r_state == ST_IDLE) || (w_state_nxt == ST_IDLE) || w_wrap) begin
      w_cnt_nxt = '0;
    end
    w_clk_nxt = (w_state_nxt != ST_IDLE) && (w_cnt_nxt < (w_n_nxt >> 1));
  end

  // Datapath and output registers; every output leaves straight from a flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_n_lat    <= L_MIN;
      r_clk_data <= 1'b0;
      r_strobe   <= 1'b0;
      r_active   <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_n_lat    <= w_n_nxt;
      r_clk_data <= w_clk_nxt;
      r_strobe   <= w_start;
      r_active   <= (w_state_nxt != ST_IDLE);
      r_cfg_err  <= w_start && w_low_req;
    end
  end

  strobe_counter #(
    .PCNT_W(PCNT_W)
  ) u_strobe_counter (
    .clk          (clk),
    .rst          (rst),
    .i_strobe     (r_strobe),
    .o_period_cnt (bus.period_cnt)
  );

  assign bus.clk_data    = r_clk_data;
  assign bus.data_strobe = r_strobe;
  assign bus.active      = r_active;
  assign bus.cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_data_clk_gen.sv
// tb/tb_data_clk_gen.sv - directed scoreboard bench for data_clk_gen
module tb_data_clk_gen;

  typedef struct {
    bit clk_data;
    bit strobe;
    bit active;
    bit cfg_err;
    int pcnt;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   cyc;
  int   pc;
  exp_t sb[$];

  data_clk_gen_if #(.DIV_W(6), .PCNT_W(16)) bus ();

  data_clk_gen #(.DIV_W(6), .PCNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " clk_data"}, 32'(bus.clk_data), 32'd0);
    chk({tag, " strobe"}, 32'(bus.data_strobe), 32'd0);
    chk({tag, " active"}, 32'(bus.active), 32'd0);
    chk({tag, " cfg_err"}, 32'(bus.cfg_err), 32'd0);
    chk({tag, " period_cnt"}, 32'(bus.period_cnt), 32'd0);
  endtask

  task automatic step(input bit en_v, input logic [5:0] div_v, input bit e_clk,
                      input bit e_stb, input bit e_act, input bit e_cfg, input int e_pc);
    exp_t e;
    e = '{clk_data: e_clk, strobe: e_stb, active: e_act, cfg_err: e_cfg, pcnt: e_pc};
    sb.push_back(e);
    bus.en = en_v;
    bus.div_ratio = div_v;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk($sformatf("c%0d clk_data", cyc), 32'(bus.clk_data), 32'(e.clk_data));
    chk($sformatf("c%0d strobe", cyc), 32'(bus.data_strobe), 32'(e.strobe));
    chk($sformatf("c%0d active", cyc), 32'(bus.active), 32'(e.active));
    chk($sformatf("c%0d cfg_err", cyc), 32'(bus.cfg_err), 32'(e.cfg_err));
    chk($sformatf("c%0d period_cnt", cyc), 32'(bus.period_cnt), 32'(e.pcnt & 16'hffff));
    cyc++;
  endtask

  // One full period with en held high; div0 is presented at the latch edge, divr afterwards
  task automatic period(input int n, input logic [5:0] div0, input logic [5:0] divr, input bit cfg);
    for (int i = 0; i < n; i++) begin
      step(1'b1, (i == 0) ? div0 : divr, i < n / 2, i == 0, 1'b1, cfg && (i == 0),
           (i == 0) ? pc : pc + 1);
    end
    pc++;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc = 0;
    pc = 0;
    rst = 1'b1;
    bus.en = 1'b0;
    bus.div_ratio = 6'd4;
    #12;
    chk_all_zero("reset");
    rst = 1'b0;

    // N=4 repeating 1100
    repeat (3) period(4, 6'd4, 6'd4, 1'b0);
    // N=5: two high, three low
    repeat (2) period(5, 6'd5, 6'd5, 1'b0);
    // ratio change mid-period only lands at the next start
    period(4, 6'd4, 6'd6, 1'b0);
    period(6, 6'd6, 6'd6, 1'b0);
    // ratio 1 clamps to 2 and flags every start
    repeat (3) period(2, 6'd1, 6'd1, 1'b1);
    period(8, 6'd8, 6'd8, 1'b0);

    // en drops at cnt=1 with N=8: period completes, then idle without strobe
    for (int i = 0; i < 8; i++) begin
      step(i <= 1, 6'd8, i < 4, i == 0, 1'b1, 1'b0, (i == 0) ? pc : pc + 1);
    end
    pc++;
    repeat (4) step(1'b0, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, pc);

    // single-cycle en pulse still yields a full N=4 period
    for (int i = 0; i < 4; i++) begin
      step(i == 0, 6'd4, i < 2, i == 0, 1'b1, 1'b0, (i == 0) ? pc : pc + 1);
    end
    pc++;
    repeat (2) step(1'b0, 6'd4, 1'b0, 1'b0, 1'b0, 1'b0, pc);

    // en dropped at cnt=1, seen again at cnt=6: seamless continuation
    for (int i = 0; i < 8; i++) begin
      step((i <= 1) || (i == 7), 6'd8, i < 4, i == 0, 1'b1, 1'b0, (i == 0) ? pc : pc + 1);
    end
    pc++;
    period(8, 6'd8, 6'd8, 1'b0);

    // N=6 aborted by reset at cnt=2
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 6'd6, i < 3, i == 0, 1'b1, 1'b0, (i == 0) ? pc : pc + 1);
    end
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk);
    #1;
    chk_all_zero("rst_held");
    rst = 1'b0;
    pc = 0;
    repeat (2) period(6, 6'd6, 6'd6, 1'b0);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_clk_gen.md
DATA_CLK_GEN -- requirements
Module: data_clk_gen

Interface
REQ-001 Parameter DIV_W, default 6: width of div_ratio and the internal period counter.
REQ-002 Parameter PCNT_W, default 16: width of period_cnt.
REQ-003 clk  input  1: single system clock; all state changes on its rising edge.
REQ-004 rst  input  1: reset, asynchronous and active-high.
REQ-005 en  input  1: level request to generate the data clock.
REQ-006 div_ratio  input  DIV_W: period N of clk_data in clk cycles; valid range 2..2^DIV_W-1.
REQ-007 clk_data  output  1: generated data clock, registered.
REQ-008 data_strobe  output  1: one-cycle pulse coincident with each clk_data rising edge, registered.
REQ-009 active  output  1: high while the state is RUN or STOP.
REQ-010 cfg_err  output  1: one-cycle pulse when a latched div_ratio is below 2.
REQ-011 period_cnt  output  PCNT_W: count of emitted data_strobe pulses, wraps at 2^PCNT_W.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and STOP.
REQ-013 IDLE -> RUN on the first clk edge with en=1; after that edge: cnt=0, clk_data=1, data_strobe=1, active=1.
REQ-014 At every period start (cnt=0), div_ratio SHALL be latched into n_lat; a value below 2 latches as 2 and pulses cfg_err in the same cycle as data_strobe.
REQ-015 In RUN, cnt SHALL increment by 1 per clk and wrap from n_lat-1 to 0; each wrap is a new period start.
REQ-016 clk_data SHALL be 1 for cnt < floor(n_lat/2) and 0 otherwise; an odd N gives the extra cycle to the low phase.
REQ-017 data_strobe SHALL be 1 only in the cycle where cnt=0 and the state is RUN.
REQ-018 A div_ratio change mid-period SHALL take effect only at the next period start.
REQ-019 en=0 in RUN SHALL move the FSM to STOP; the current period completes with unchanged timing.
REQ-020 In STOP, the edge that would wrap cnt to 0 SHALL go to IDLE with clk_data=0 and active=0, and no strobe is emitted.
REQ-021 en=1 seen in STOP SHALL return the FSM to RUN with no gap and no extra strobe.
REQ-022 Single-cycle en pulses SHALL always produce at least one full period.
REQ-023 period_cnt SHALL increment in the cycle after each data_strobe, wrap silently, and hold its value in IDLE.
REQ-024 All outputs SHALL be direct register outputs with no combinational path from inputs.

Reset
REQ-025 Asserting rst SHALL immediately force: state=IDLE, cnt=0, n_lat=2, clk_data=0, data_strobe=0, active=0, cfg_err=0, period_cnt=0.
REQ-026 rst asserted mid-period SHALL abort the period; after release, generation restarts only per REQ-013.

Structure
REQ-027 The FSM state encoding and the minimum-ratio constant (2) SHALL live in the shared PHY package.
REQ-028 The block SHALL be one module plus one sub-module, strobe_counter, which holds period_cnt.

Verification
REQ-029 N=4, en held high -> clk_data pattern 1100 repeating; data_strobe every 4th cycle; period_cnt=+1 per period.
REQ-030 N=5 -> high for 2 cycles, low for 3 cycles; strobe spacing 5 cycles.
REQ-031 N changes from 4 to 6 at cnt=1 -> the current period stays 4 cycles and the next period is 6 cycles (3 high, 3 low).
REQ-032 en drops at cnt=1 with N=8 -> clk_data low for cnt 4..7, then IDLE with active=0 and no further strobe; en reasserted at cnt=6 -> the strobe follows at the next cycle, seamless.
REQ-033 div_ratio=1 -> cfg_err pulses with each strobe; output period is 2 (pattern 10).
REQ-034 rst asserted at cnt=2 of N=6 -> all outputs 0 asynchronously, period_cnt=0; after release with en=1, the first strobe comes one edge later.
